// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle MIPS control unit. Walks each instruction through
// fetch / decode / execute / memory / writeback states and drives the ALU
// control code, ALU operand selects and the datapath enables.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode, funct       IR[31:26] and IR[5:0], valid from DECODE onward
//   alu_zero            ALU zero flag, resolves beq
//   alu_overflow        ALU signed overflow flag, traps add/sub/addi
//   mem_ready           memory access completes this cycle
//   alu_ctrl            ALU operation code
//   alu_src_a/b         ALU operand selects
//   pc_src, pc_en       PC source select and load enable
//   iord                memory address select (0=PC, 1=ALUOut)
//   mem_read/mem_write  memory strobes
//   ir_write            IR load enable
//   reg_dst, mem_to_reg register file destination / data selects
//   reg_write           register file write enable
//   ovf_exc, illegal_op registered one-cycle exception pulses
//   state               current state, for debug
module mips_multicycle_ctrl #(
    parameter logic [3:0] ALU_AND  = 4'd0,
    parameter logic [3:0] ALU_OR   = 4'd1,
    parameter logic [3:0] ALU_ADD  = 4'd2,
    parameter logic [3:0] ALU_SUB  = 4'd6,
    parameter logic [3:0] ALU_SLT  = 4'd7,
    parameter logic [3:0] ALU_NOR  = 4'd12,
    parameter bit         TRAP_OVF = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       mem_ready,
    output logic [3:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       ovf_exc,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        ADDI_EX  = 4'd8,
        ADDI_WB  = 4'd9,
        BEQ      = 4'd10,
        JUMP     = 4'd11,
        ILLEGAL  = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // Returns {valid, alu code} for an R-type funct field.
    function automatic logic [4:0] funct_decode(input logic [5:0] f);
        logic [4:0] r;
        case (f)
            FN_ADD:  r = {1'b1, ALU_ADD};
            FN_SUB:  r = {1'b1, ALU_SUB};
            FN_AND:  r = {1'b1, ALU_AND};
            FN_OR:   r = {1'b1, ALU_OR};
            FN_SLT:  r = {1'b1, ALU_SLT};
            FN_NOR:  r = {1'b1, ALU_NOR};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    state_e     state_q, state_d;
    logic       ovf_exc_q, ovf_exc_d;
    logic       illegal_op_q, illegal_op_d;
    logic [4:0] fdec_s;
    logic       add_sub_s;
    logic       pc_en_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;

    assign fdec_s    = funct_decode(funct);
    assign add_sub_s = (funct == FN_ADD) || (funct == FN_SUB);

    // State and exception pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            ovf_exc_q    <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ovf_exc_q    <= ovf_exc_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Next-state logic and Moore output decode (pc_en/ir_write also see inputs).
    always_comb begin
        state_d      = state_q;
        ovf_exc_d    = 1'b0;
        illegal_op_d = 1'b0;
        alu_ctrl     = 4'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_src       = 2'b00;
        iord         = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        pc_en_s      = 1'b0;
        ir_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read_s = 1'b1;
                alu_src_b  = 2'b01;
                alu_ctrl   = ALU_ADD;
                ir_write_s = mem_ready;
                pc_en_s    = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = RTYPE_EX;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                if (opcode == OP_LW) begin
                    state_d = MEMRD;
                end else begin
                    state_d = MEMWR;
                end
            end
            MEMRD: begin
                iord       = 1'b1;
                mem_read_s = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end else begin
                    state_d = MEMRD;
                end
            end
            MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
                state_d     = FETCH;
            end
            MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else begin
                    state_d = MEMWR;
                end
            end
            RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_ctrl  = fdec_s[3:0];
                if (!fdec_s[4]) begin
                    state_d = ILLEGAL;
                end else if (TRAP_OVF && add_sub_s && alu_overflow) begin
                    // Trapped overflow skips writeback entirely.
                    state_d   = FETCH;
                    ovf_exc_d = 1'b1;
                end else begin
                    state_d = RTYPE_WB;
                end
            end
            RTYPE_WB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
                state_d     = FETCH;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                if (TRAP_OVF && alu_overflow) begin
                    state_d   = FETCH;
                    ovf_exc_d = 1'b1;
                end else begin
                    state_d = ADDI_WB;
                end
            end
            ADDI_WB: begin
                reg_write_s = 1'b1;
                state_d     = FETCH;
            end
            BEQ: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en_s   = alu_zero;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_src  = 2'b10;
                pc_en_s = 1'b1;
                state_d = FETCH;
            end
            ILLEGAL: begin
                illegal_op_d = 1'b1;
                state_d      = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Write/strobe enables are held off combinationally while reset is low,
    // so nothing reaches memory, PC, IR or registers during reset.
    assign pc_en      = pc_en_s & rst_n;
    assign ir_write   = ir_write_s & rst_n;
    assign mem_read   = mem_read_s & rst_n;
    assign mem_write  = mem_write_s & rst_n;
    assign reg_write  = reg_write_s & rst_n;
    assign ovf_exc    = ovf_exc_q;
    assign illegal_op = illegal_op_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. Two instances share stimulus:
// u_dut traps overflow, u_dut_nt does not.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, alu_overflow, mem_ready;

    logic [3:0] alu_ctrl, state;
    logic       alu_src_a, pc_en, iord, mem_read, mem_write, ir_write;
    logic [1:0] alu_src_b, pc_src;
    logic       reg_dst, mem_to_reg, reg_write, ovf_exc, illegal_op;

    logic [3:0] alu_ctrl2, state2;
    logic       alu_src_a2, pc_en2, iord2, mem_read2, mem_write2, ir_write2;
    logic [1:0] alu_src_b2, pc_src2;
    logic       reg_dst2, mem_to_reg2, reg_write2, ovf_exc2, illegal_op2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .ovf_exc(ovf_exc),
        .illegal_op(illegal_op), .state(state)
    );

    mips_multicycle_ctrl #(.TRAP_OVF(1'b0)) u_dut_nt (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
        .pc_src(pc_src2), .pc_en(pc_en2), .iord(iord2), .mem_read(mem_read2),
        .mem_write(mem_write2), .ir_write(ir_write2), .reg_dst(reg_dst2),
        .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .ovf_exc(ovf_exc2),
        .illegal_op(illegal_op2), .state(state2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'b100011; funct = 6'b000000;
        alu_zero = 1'b0; alu_overflow = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        // Reset state: FETCH, strobes forced off even with mem_ready=1.
        chk("rst_state", state, 4'd0);
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_ir_write", ir_write, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_ovf", ovf_exc, 1'b0);
        chk("rst_ill", illegal_op, 1'b0);
        rst_n = 1'b1; #1;
        chk("fetch_pc_en", pc_en, 1'b1);
        chk("fetch_ir_write", ir_write, 1'b1);
        chk("fetch_alu_ctrl", alu_ctrl, 4'd2);
        chk("fetch_src_b", alu_src_b, 2'b01);
        chk("fetch_mem_read", mem_read, 1'b1);

        // lw: FETCH DECODE MEMADR MEMRD MEMWB
        tick();
        chk("lw_decode", state, 4'd1);
        chk("lw_dec_src_b", alu_src_b, 2'b11);
        chk("lw_dec_rw", reg_write, 1'b0);
        tick();
        chk("lw_memadr", state, 4'd2);
        chk("lw_adr_src", {alu_src_a, alu_src_b}, 3'b110);
        chk("lw_adr_rw", reg_write, 1'b0);
        tick();
        chk("lw_memrd", state, 4'd3);
        chk("lw_rd_iord", {iord, mem_read}, 2'b11);
        chk("lw_rd_rw", reg_write, 1'b0);
        tick();
        chk("lw_memwb", state, 4'd4);
        chk("lw_wb_rw", {reg_write, mem_to_reg, reg_dst}, 3'b110);
        tick();
        chk("lw_back_fetch", state, 4'd0);
        chk("lw_fetch_rw", reg_write, 1'b0);

        // R-type SLT
        opcode = 6'b000000; funct = 6'b101010;
        tick(); tick();
        chk("slt_ex", state, 4'd6);
        chk("slt_alu", alu_ctrl, 4'd7);
        chk("slt_src", {alu_src_a, alu_src_b}, 3'b100);
        tick();
        chk("slt_wb", state, 4'd7);
        chk("slt_wb_rw", {reg_write, reg_dst, mem_to_reg}, 3'b110);
        tick();
        chk("slt_fetch", state, 4'd0);

        // R-type NOR
        funct = 6'b100111;
        tick(); tick();
        chk("nor_alu", alu_ctrl, 4'd12);
        tick(); tick();
        chk("nor_fetch", state, 4'd0);

        // R-type unknown funct -> ILLEGAL
        funct = 6'b000111;
        tick(); tick();
        chk("badfn_ex", state, 4'd6);
        chk("badfn_rw", reg_write, 1'b0);
        tick();
        chk("ill_state", state, 4'd12);
        chk("ill_writes", {reg_write, mem_write, pc_en, ir_write}, 4'b0000);
        chk("ill_pulse_early", illegal_op, 1'b0);
        tick();
        chk("ill_fetch", state, 4'd0);
        chk("ill_pulse", illegal_op, 1'b1);
        chk("ill_fetch_rw", reg_write, 1'b0);
        tick();
        chk("ill_pulse_end", illegal_op, 1'b0);
        // Now in DECODE: switch to j
        opcode = 6'b000010; #1;
        tick();
        chk("j_state", state, 4'd11);
        chk("j_pc", {pc_en, pc_src}, 3'b110);
        tick();
        chk("j_fetch", state, 4'd0);

        // beq taken
        opcode = 6'b000100; alu_zero = 1'b1;
        tick(); tick();
        chk("beq_t_state", state, 4'd10);
        chk("beq_t_pc", {pc_en, pc_src}, 3'b101);
        chk("beq_t_alu", alu_ctrl, 4'd6);
        tick();
        chk("beq_t_fetch", state, 4'd0);
        // beq not taken
        alu_zero = 1'b0;
        tick(); tick();
        chk("beq_n_pc_en", pc_en, 1'b0);
        tick();
        chk("beq_n_fetch", state, 4'd0);

        // addi, no overflow
        opcode = 6'b001000;
        tick(); tick();
        chk("addi_ex", state, 4'd8);
        chk("addi_src_b", alu_src_b, 2'b10);
        tick();
        chk("addi_wb", state, 4'd9);
        chk("addi_wb_rw", {reg_write, reg_dst, mem_to_reg}, 3'b100);
        tick();

        // add with overflow: trapping DUT skips writeback, other writes back
        opcode = 6'b000000; funct = 6'b100000; alu_overflow = 1'b1;
        tick(); tick();
        chk("ovf_ex", state, 4'd6);
        chk("ovf_pre", ovf_exc, 1'b0);
        tick();
        chk("ovf_fetch", state, 4'd0);
        chk("ovf_rw", reg_write, 1'b0);
        chk("ovf_pulse", ovf_exc, 1'b1);
        chk("nt_wb", state2, 4'd7);
        chk("nt_wb_rw", reg_write2, 1'b1);
        chk("nt_no_exc", ovf_exc2, 1'b0);
        alu_overflow = 1'b0;
        tick();
        chk("ovf_pulse_end", ovf_exc, 1'b0);
        chk("nt_fetch", state2, 4'd0);
        tick();
        chk("mid_ex", state, 4'd6);

        // Reset mid-RTYPE_EX
        rst_n = 1'b0; #1;
        chk("mid_rst_state", state, 4'd0);
        chk("mid_rst_rw", reg_write, 1'b0);
        chk("mid_rst_state2", state2, 4'd0);
        chk("mid_rst_strobes", {pc_en, ir_write, mem_read, mem_write}, 4'b0000);
        tick();
        rst_n = 1'b1; #1;
        chk("rel_fetch", {pc_en, ir_write, alu_ctrl}, 6'b110010);

        // FETCH with memory stalled 3 cycles
        mem_ready = 1'b0; opcode = 6'b101011; #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_state", state, 4'd0);
            chk("stall_en", {ir_write, pc_en}, 2'b00);
            tick();
        end
        mem_ready = 1'b1; #1;
        chk("stall_done_en", {ir_write, pc_en}, 2'b11);
        tick();
        chk("stall_decode", state, 4'd1);
        chk("stall_decode_en", {ir_write, pc_en}, 2'b00);

        // sw with memory stalled 2 cycles
        tick();
        chk("sw_memadr", state, 4'd2);
        tick();
        mem_ready = 1'b0; #1;
        chk("sw_wr1", {state, mem_write, iord}, 6'b010111);
        tick();
        chk("sw_wr2", {state, mem_write}, 5'b01011);
        tick();
        mem_ready = 1'b1; #1;
        chk("sw_wr3", {state, mem_write}, 5'b01011);
        tick();
        chk("sw_fetch", state, 4'd0);
        chk("sw_done", mem_write, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
